prbs31_rx_checker: RTL and testbench
====================================

Name: prbs31_rx_checker

Overview:
- Receive-side counterpart of the GTP PRBS transmit test. Consumes the 16-bit parallel RX words from the GTP receiver on the RX user clock.
- Checks them against PRBS-31 (x^31+x^28+1) with a self-synchronising checker, so no word or bit alignment is needed.
- Tracks lock, and keeps bit-error, word and errored-word statistics for LEDs and ILA/VIO readout.
- Upstream generator emits serial PRBS-31 packed LSB-first, which is GTP TX bit order.

Parameters:
- WIDTH, 16, RX word width in bits; must be 16 or 32.
- LOCK_WORDS, 64, consecutive clean checked words required to declare lock.
- UNLOCK_ERRORED_WORDS, 4, errored words within one window that drop lock.
- UNLOCK_WINDOW, 256, window length in valid words while LOCKED.
- ERROR_COUNTER_WIDTH, 32, width of bit_error_count and errored_word_count.
- WORD_COUNTER_WIDTH, 48, width of word_count.

Ports:
- clock, input, 1, RX user clock (rxusrclk2).
- reset, input, 1, asynchronous, active-high.
- rxdata_valid, input, 1, qualifies rxdata.
- rxdata, input, WIDTH, received word; bit 0 is the earliest bit on the wire.
- clear_counters, input, 1, synchronous clear of all statistics.
- locked, output, 1, checker is in LOCKED.
- error_word, output, 1, one-cycle pulse: the last checked word had at least one error.
- bit_error_count, output, ERROR_COUNTER_WIDTH, saturating bit errors counted while LOCKED.
- errored_word_count, output, ERROR_COUNTER_WIDTH, saturating errored words counted while LOCKED.
- word_count, output, WORD_COUNTER_WIDTH, saturating valid words checked while LOCKED.
- lock_loss_count, output, 8, saturating count of LOCKED->HUNT transitions.

Behaviour:
- Reset (async, active-high): all outputs 0, history 0, state PRIME, all internal counters 0.
- When rxdata_valid=0, nothing changes: history, FSM and counters hold, and error_word=0 the following cycle.
- Bit stream: s[0..30] = hist (oldest first), s[31..31+WIDTH-1] = rxdata[0..WIDTH-1].
- Error vector: e[i] = s[31+i] ^ s[i+3] ^ s[i], for i in 0..WIDTH-1.
- History update: hist takes the newest 31 bits of s on every valid word.
- Zero guard: if hist==0 and rxdata==0, the word is errored and counts as WIDTH bit errors. Without this, all-zero input would pass the check.
- Stage 1 (edge after the valid word is sampled): register e, its popcount and the errored flag. error_word = errored flag; it is asserted only in HUNT or LOCKED.
- Stage 2 (next edge): FSM and statistics update from the stage-1 registers. Latency from rxdata sample to counter/locked update is 2 clocks.
- State PRIME:
  - No checking takes place.
  - After ceil(31/WIDTH) valid words (2 for WIDTH=16), go to HUNT.
- State HUNT:
  - A clean word increments clean_run; an errored word zeroes clean_run.
  - When clean_run reaches LOCK_WORDS, go to LOCKED and zero the window counters.
- State LOCKED:
  - locked=1.
  - Every checked word increments word_count and win_words.
  - An errored word increments errored_word_count and win_err, and adds the popcount to bit_error_count.
  - When win_err reaches UNLOCK_ERRORED_WORDS, go to HUNT, increment lock_loss_count and zero clean_run. This takes priority over window end.
  - When win_words reaches UNLOCK_WINDOW, zero both win_words and win_err.
- Statistics are not accumulated in HUNT or PRIME.
- All statistics saturate at all-ones and never wrap.
- clear_counters: zeroes the four statistics outputs. It wins over a coincident increment. It does not affect the FSM, history or locked.
- One channel bit error is seen three times (at positions p, p+28 and p+31), so bit_error_count reads 3x the true channel BER. This is documented, not corrected.
- Reset asserted mid-LOCKED: immediate return to PRIME with statistics zeroed.

Decomposition:
- Shared include prbs_check_pkg holds:
  - Tap constants PRBS31_TAP_A=31 and PRBS31_TAP_B=28.
  - State encodings PRIME=2'd0, HUNT=2'd1, LOCKED=2'd2.
  - Macro SAT_INC for saturating increment.
- One sub-module, prbs31_error_vector: combinational, takes hist and rxdata, produces e[WIDTH-1:0] and popcount. It is reused by a future 32-bit SFP-lane checker.

Test Plan:
- Clean stream: clean PRBS-31, valid every cycle from word W0.
  - locked rises 2 clocks after W65 is sampled (2 priming words + 64 clean).
  - All statistics stay 0 except word_count, which increments once per word.
- Single flip: flip bit 0 of word W100 while LOCKED.
  - error_word pulses for W100 and W101 (bits 12 and 15).
  - bit_error_count=3, errored_word_count=2, locked stays 1.
- Burst: 4 errored words within 256 words while LOCKED.
  - locked=0 and lock_loss_count=1 two clocks after the 4th errored word.
  - Relock after 64 clean words.
- All-zero input: rxdata=0 continuously.
  - Checker never locks; error_word is 1 every cycle after priming.
  - All statistics stay 0.
- Valid gaps: rxdata_valid randomly low for 50% of cycles on the clean stream.
  - locked rises after exactly 66 valid words.
  - word_count equals valid words after lock; no errors.
- Clear and reset:
  - clear_counters coincident with an errored word: all statistics read 0 the next cycle.
  - reset mid-LOCKED: all outputs 0 asynchronously; relock follows the clean-stream timing.

Source files
------------

// File: rtl/prbs_check_pkg.sv
// -----------------------------------------------------------------------------
// prbs_check_pkg
//   Shared definitions for the PRBS receive checkers.
//   - PRBS31_TAP_A / PRBS31_TAP_B : taps of x^31 + x^28 + 1.
//   - check_state_t               : checker FSM encoding (PRIME/HUNT/LOCKED).
//   - `SAT_INC(v)                 : saturating increment, holds at all-ones.
//   This file must be compiled ahead of any file that uses the macro.
// -----------------------------------------------------------------------------
`ifndef PRBS_CHECK_PKG_MACROS
`define PRBS_CHECK_PKG_MACROS
`define SAT_INC(v) ((&(v)) ? (v) : ((v) + 1'b1))
`endif

package prbs_check_pkg;

    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } check_state_t;

endpackage

// File: rtl/prbs31_error_vector.sv
// -----------------------------------------------------------------------------
// prbs31_error_vector
//   Combinational self-synchronising PRBS-31 check of one received word.
//   The stream is s[0..30] = hist (oldest first) followed by rxdata[0..WIDTH-1].
//   Each new bit must equal the XOR of the bits 31 and 28 positions earlier,
//   so e[i] = s[31+i] ^ s[i+3] ^ s[i].
//   Ports:
//     hist     in  31     previous 31 received bits, bit 0 oldest
//     rxdata   in  WIDTH  received word, bit 0 earliest on the wire
//     err_vec  out WIDTH  per-bit check result (1 = mismatch)
//     popcount out        number of ones in err_vec
// -----------------------------------------------------------------------------
module prbs31_error_vector
    import prbs_check_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int POP_W = $clog2(WIDTH + 1)
) (
    input  logic [PRBS31_TAP_A-1:0] hist,
    input  logic [WIDTH-1:0]        rxdata,
    output logic [WIDTH-1:0]        err_vec,
    output logic [POP_W-1:0]        popcount
);

    localparam int TAP_GAP = PRBS31_TAP_A - PRBS31_TAP_B;

    logic [PRBS31_TAP_A+WIDTH-1:0] stream;

    assign stream = {rxdata, hist};

    always_comb begin
        err_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            err_vec[i] = stream[PRBS31_TAP_A + i] ^ stream[i + TAP_GAP] ^ stream[i];
        end
    end

    always_comb begin
        popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcount = popcount + POP_W'(err_vec[i]);
        end
    end

endmodule

// File: rtl/prbs31_rx_checker.sv
// -----------------------------------------------------------------------------
// prbs31_rx_checker
//   Receive-side PRBS-31 checker for GTP parallel RX words (LSB-first packing).
//   Self-synchronising, so no word or bit alignment is required. Tracks lock
//   and accumulates saturating statistics while LOCKED.
//   WIDTH must be 16 or 32.
//   Ports:
//     clock              in   RX user clock (rxusrclk2)
//     reset              in   asynchronous, active-high
//     rxdata_valid       in   qualifies rxdata
//     rxdata             in   received word, bit 0 earliest on the wire
//     clear_counters     in   synchronous clear of the four statistics
//     locked             out  checker is in LOCKED
//     error_word         out  pulse: last checked word had at least one error
//     bit_error_count    out  saturating bit errors while LOCKED
//     errored_word_count out  saturating errored words while LOCKED
//     word_count         out  saturating checked words while LOCKED
//     lock_loss_count    out  saturating LOCKED->HUNT transitions
//   Note: one channel bit error shows up three times in the error vector
//   (positions p, p+28, p+31), so bit_error_count reads 3x the channel BER.
// -----------------------------------------------------------------------------
module prbs31_rx_checker
    import prbs_check_pkg::*;
#(
    parameter int WIDTH                = 16,
    parameter int LOCK_WORDS           = 64,
    parameter int UNLOCK_ERRORED_WORDS = 4,
    parameter int UNLOCK_WINDOW        = 256,
    parameter int ERROR_COUNTER_WIDTH  = 32,
    parameter int WORD_COUNTER_WIDTH   = 48
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rxdata_valid,
    input  logic [WIDTH-1:0]               rxdata,
    input  logic                           clear_counters,
    output logic                           locked,
    output logic                           error_word,
    output logic [ERROR_COUNTER_WIDTH-1:0] bit_error_count,
    output logic [ERROR_COUNTER_WIDTH-1:0] errored_word_count,
    output logic [WORD_COUNTER_WIDTH-1:0]  word_count,
    output logic [7:0]                     lock_loss_count
);

    localparam int HIST_W      = PRBS31_TAP_A;
    localparam int POP_W       = $clog2(WIDTH + 1);
    localparam int PRIME_WORDS = (HIST_W + WIDTH - 1) / WIDTH;
    localparam int PRIME_W     = $clog2(PRIME_WORDS + 1);
    localparam int RUN_W       = $clog2(LOCK_WORDS + 1);
    localparam int WIN_W       = $clog2(UNLOCK_WINDOW + 1);
    localparam int WERR_W      = $clog2(UNLOCK_ERRORED_WORDS + 1);
    localparam int ECW         = ERROR_COUNTER_WIDTH;

    function automatic logic [ECW-1:0] sat_add_err(input logic [ECW-1:0] acc,
                                                   input logic [POP_W-1:0] inc);
        logic [ECW:0] sum;
        sum = {1'b0, acc} + (ECW + 1)'(inc);
        return sum[ECW] ? '1 : sum[ECW-1:0];
    endfunction

    logic [HIST_W-1:0]  hist;
    logic [HIST_W-1:0]  hist_next;
    logic [WIDTH-1:0]   err_vec;
    logic [POP_W-1:0]   pop_raw;
    logic               zero_word;
    logic               err_raw;
    logic [POP_W-1:0]   pop_word;

    logic               vld_p1;
    logic               err_p1;
    logic [POP_W-1:0]   pop_p1;

    check_state_t       state;
    check_state_t       state_next;
    logic [PRIME_W-1:0] prime_cnt;
    logic [PRIME_W-1:0] prime_cnt_next;
    logic [PRIME_W-1:0] prime_inc;
    logic [RUN_W-1:0]   clean_run;
    logic [RUN_W-1:0]   clean_run_next;
    logic [RUN_W-1:0]   clean_inc;
    logic [WIN_W-1:0]   win_words;
    logic [WIN_W-1:0]   win_words_next;
    logic [WIN_W-1:0]   win_words_inc;
    logic [WERR_W-1:0]  win_err;
    logic [WERR_W-1:0]  win_err_next;
    logic [WERR_W-1:0]  win_err_inc;
    logic               count_word;
    logic               lock_drop;

    prbs31_error_vector #(
        .WIDTH (WIDTH),
        .POP_W (POP_W)
    ) u_error_vector (
        .hist     (hist),
        .rxdata   (rxdata),
        .err_vec  (err_vec),
        .popcount (pop_raw)
    );

    // History keeps the newest 31 bits of {rxdata, hist}.
    generate
        if (WIDTH >= HIST_W) begin : g_hist_wide
            assign hist_next = rxdata[WIDTH-1 -: HIST_W];
        end else begin : g_hist_narrow
            assign hist_next = {rxdata, hist[HIST_W-1:WIDTH]};
        end
    endgenerate

    // An all-zero history with an all-zero word satisfies the recurrence
    // trivially; treat it as a fully errored word so a dead link never locks.
    assign zero_word = (hist == '0) && (rxdata == '0);
    assign err_raw   = (|err_vec) | zero_word;
    assign pop_word  = zero_word ? POP_W'(WIDTH) : pop_raw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (rxdata_valid) begin
            hist <= hist_next;
        end
    end

    // ---- stage p1: registered check result of the sampled word ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            pop_p1 <= '0;
        end else begin
            vld_p1 <= rxdata_valid;
            if (rxdata_valid) begin
                err_p1 <= err_raw;
                pop_p1 <= pop_word;
            end
        end
    end

    // The state shown alongside the p1 result is the state that will judge it
    // on the next edge, so gating with it flags exactly the checked words.
    assign error_word = vld_p1 & err_p1 & (state != PRIME);
    assign locked     = (state == LOCKED);

    // ---- stage p2: FSM and window counters ----
    assign prime_inc     = prime_cnt + 1'b1;
    assign clean_inc     = clean_run + 1'b1;
    assign win_words_inc = win_words + 1'b1;
    assign win_err_inc   = win_err + WERR_W'(err_p1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= PRIME;
            prime_cnt <= '0;
            clean_run <= '0;
            win_words <= '0;
            win_err   <= '0;
        end else begin
            state     <= state_next;
            prime_cnt <= prime_cnt_next;
            clean_run <= clean_run_next;
            win_words <= win_words_next;
            win_err   <= win_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        prime_cnt_next = prime_cnt;
        clean_run_next = clean_run;
        win_words_next = win_words;
        win_err_next   = win_err;
        count_word     = 1'b0;
        lock_drop      = 1'b0;
        if (vld_p1) begin
            case (state)
                PRIME: begin
                    prime_cnt_next = prime_inc;
                    if (prime_inc == PRIME_W'(PRIME_WORDS)) begin
                        state_next = HUNT;
                    end
                end
                HUNT: begin
                    if (err_p1) begin
                        clean_run_next = '0;
                    end else begin
                        clean_run_next = clean_inc;
                        if (clean_inc == RUN_W'(LOCK_WORDS)) begin
                            state_next     = LOCKED;
                            win_words_next = '0;
                            win_err_next   = '0;
                        end
                    end
                end
                LOCKED: begin
                    count_word     = 1'b1;
                    win_words_next = win_words_inc;
                    win_err_next   = win_err_inc;
                    // Losing lock outranks closing the window on the same word.
                    if (win_err_inc == WERR_W'(UNLOCK_ERRORED_WORDS)) begin
                        state_next     = HUNT;
                        lock_drop      = 1'b1;
                        clean_run_next = '0;
                    end else if (win_words_inc == WIN_W'(UNLOCK_WINDOW)) begin
                        win_words_next = '0;
                        win_err_next   = '0;
                    end
                end
                default: begin
                    state_next = PRIME;
                end
            endcase
        end
    end

    // Statistics: clear_counters beats any coincident increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_error_count    <= '0;
            errored_word_count <= '0;
            word_count         <= '0;
            lock_loss_count    <= '0;
        end else if (clear_counters) begin
            bit_error_count    <= '0;
            errored_word_count <= '0;
            word_count         <= '0;
            lock_loss_count    <= '0;
        end else begin
            if (count_word) begin
                word_count <= `SAT_INC(word_count);
                if (err_p1) begin
                    errored_word_count <= `SAT_INC(errored_word_count);
                    bit_error_count    <= sat_add_err(bit_error_count, pop_p1);
                end
            end
            if (lock_drop) begin
                lock_loss_count <= `SAT_INC(lock_loss_count);
            end
        end
    end

endmodule

// File: tb/tb_prbs31_rx_checker.sv
module tb_prbs31_rx_checker;

    localparam int WIDTH       = 16;
    localparam int LOCK_WORDS  = 64;
    localparam int UNLOCK_ERR  = 4;
    localparam int UNLOCK_WIN  = 256;
    localparam int PRIME_WORDS = (31 + WIDTH - 1) / WIDTH;
    localparam longint ECNT_MAX = 64'hFFFF_FFFF;
    localparam longint WCNT_MAX = 64'hFFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rxdata_valid = 1'b0;
    logic [WIDTH-1:0] rxdata = '0;
    logic             clear_counters = 1'b0;
    logic             locked;
    logic             error_word;
    logic [31:0]      bit_error_count;
    logic [31:0]      errored_word_count;
    logic [47:0]      word_count;
    logic [7:0]       lock_loss_count;

    prbs31_rx_checker #(
        .WIDTH                (WIDTH),
        .LOCK_WORDS           (LOCK_WORDS),
        .UNLOCK_ERRORED_WORDS (UNLOCK_ERR),
        .UNLOCK_WINDOW        (UNLOCK_WIN),
        .ERROR_COUNTER_WIDTH  (32),
        .WORD_COUNTER_WIDTH   (48)
    ) dut (
        .clock              (clk),
        .reset              (rst),
        .rxdata_valid       (rxdata_valid),
        .rxdata             (rxdata),
        .clear_counters     (clear_counters),
        .locked             (locked),
        .error_word         (error_word),
        .bit_error_count    (bit_error_count),
        .errored_word_count (errored_word_count),
        .word_count         (word_count),
        .lock_loss_count    (lock_loss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        bit     lk;
        longint bec;
        longint ewc;
        longint wc;
        longint llc;
    } stat_t;

    bit    ew_q[$];
    stat_t st_q[$];

    // ---------------- transmit-side PRBS-31 source ----------------
    bit gq[$];

    task automatic seed_gen();
        gq.delete();
        for (int k = 0; k < 31; k++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[$urandom_range(0, 30)] = 1'b1;
    endtask

    task automatic gen_word(output logic [WIDTH-1:0] w);
        bit b;
        for (int i = 0; i < WIDTH; i++) begin
            b = gq[0] ^ gq[3];     // bit n = bit n-31 xor bit n-28
            gq.push_back(b);
            void'(gq.pop_front());
            w[i] = b;
        end
    endtask

    // ---------------- word-level reference model ----------------
    bit     rq[$];                 // last 31 received bits, oldest first
    int     m_state;               // 0 PRIME, 1 HUNT, 2 LOCKED
    int     m_prime, m_clean, m_win_words, m_win_err;
    longint m_bec, m_ewc, m_wc, m_llc;
    bit     pend;
    bit     pend_err;
    int     pend_pop;

    task automatic model_reset();
        rq.delete();
        for (int k = 0; k < 31; k++) rq.push_back(1'b0);
        m_state = 0; m_prime = 0; m_clean = 0; m_win_words = 0; m_win_err = 0;
        m_bec = 0; m_ewc = 0; m_wc = 0; m_llc = 0;
        pend = 0; pend_err = 0; pend_pop = 0;
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_judge(input bit err, input int pop);
        case (m_state)
            0: begin
                m_prime++;
                if (m_prime == PRIME_WORDS) m_state = 1;
            end
            1: begin
                if (err) m_clean = 0;
                else begin
                    m_clean++;
                    if (m_clean == LOCK_WORDS) begin
                        m_state = 2; m_win_words = 0; m_win_err = 0;
                    end
                end
            end
            default: begin
                m_wc = sat(m_wc + 1, WCNT_MAX);
                m_win_words++;
                if (err) begin
                    m_ewc = sat(m_ewc + 1, ECNT_MAX);
                    m_bec = sat(m_bec + pop, ECNT_MAX);
                    m_win_err++;
                end
                if (m_win_err == UNLOCK_ERR) begin
                    m_state = 1; m_llc = sat(m_llc + 1, 255); m_clean = 0;
                end else if (m_win_words == UNLOCK_WIN) begin
                    m_win_words = 0; m_win_err = 0;
                end
            end
        endcase
    endtask

    task automatic model_check_word(input logic [WIDTH-1:0] d, output bit err, output int pop);
        bit s[$];
        bit allz;
        s = rq;
        allz = (d == '0);
        foreach (rq[k]) if (rq[k]) allz = 1'b0;
        for (int i = 0; i < WIDTH; i++) s.push_back(d[i]);
        pop = 0;
        for (int i = 0; i < WIDTH; i++) if (s[31 + i] ^ s[i + 3] ^ s[i]) pop++;
        err = (pop != 0) || allz;
        if (allz) pop = WIDTH;
        rq.delete();
        for (int k = WIDTH; k < WIDTH + 31; k++) rq.push_back(s[k]);
    endtask

    // One clock of stimulus. The word captured on the previous edge is judged
    // on this edge, together with any clear_counters issued now.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit clr);
        bit     e;
        int     p;
        stat_t  snap;
        if (pend) model_judge(pend_err, pend_pop);
        if (clr) begin
            m_bec = 0; m_ewc = 0; m_wc = 0; m_llc = 0;
        end
        if (pend) begin
            snap.lk = (m_state == 2); snap.bec = m_bec; snap.ewc = m_ewc;
            snap.wc = m_wc; snap.llc = m_llc;
            st_q.push_back(snap);
        end
        pend = 0;
        if (v) begin
            model_check_word(d, e, p);
            ew_q.push_back(e && (m_state != 0));
            pend = 1; pend_err = e; pend_pop = p;
        end
        rxdata_valid   = v;
        rxdata         = d;
        clear_counters = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rxdata_valid = 1'b0; rxdata = '0; clear_counters = 1'b0;
        rst = 1'b1;
        #2;
        check({tag, "_rst_locked"}, locked, 0);
        check({tag, "_rst_error_word"}, error_word, 0);
        check({tag, "_rst_bec"}, bit_error_count, 0);
        check({tag, "_rst_ewc"}, errored_word_count, 0);
        check({tag, "_rst_wc"}, word_count, 0);
        check({tag, "_rst_llc"}, lock_loss_count, 0);
        model_reset();
        ew_q.delete();
        st_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic vq0, vq1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vq0 <= 1'b0;
            vq1 <= 1'b0;
        end else begin
            vq0 <= rxdata_valid;
            vq1 <= vq0;
        end
    end

    always @(negedge clk) begin : monitor
        bit    ex;
        stat_t sx;
        if (!rst) begin
            if (vq0) begin
                if (ew_q.size() == 0) check("ew_queue_empty", 1, 0);
                else begin
                    ex = ew_q.pop_front();
                    check("error_word", error_word, ex);
                end
            end else begin
                check("error_word_idle", error_word, 0);
            end
            if (vq1) begin
                if (st_q.size() == 0) check("stat_queue_empty", 1, 0);
                else begin
                    sx = st_q.pop_front();
                    check("locked", locked, sx.lk);
                    check("bit_error_count", bit_error_count, sx.bec);
                    check("errored_word_count", errored_word_count, sx.ewc);
                    check("word_count", word_count, sx.wc);
                    check("lock_loss_count", lock_loss_count, sx.llc);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [WIDTH-1:0] d;
        int nvalid;

        @(posedge clk);
        #1;
        do_reset("init");

        // Clean stream with bit 0 of W100 flipped.
        seed_gen();
        for (int w = 0; w < 150; w++) begin
            gen_word(d);
            if (w == 100) d[0] = ~d[0];
            step(1'b1, d, 1'b0);
        end
        drain(3);
        check("flip_locked", locked, 1);
        check("flip_bec", bit_error_count, 3);
        check("flip_ewc", errored_word_count, 2);
        check("flip_wc", word_count, 84);
        check("flip_llc", lock_loss_count, 0);

        // Two more errored words in the same window drop lock, then relock.
        for (int w = 150; w < 250; w++) begin
            gen_word(d);
            if (w == 150) d[0] = ~d[0];
            step(1'b1, d, 1'b0);
        end
        drain(3);
        check("burst_llc", lock_loss_count, 1);
        check("burst_relocked", locked, 1);
        check("burst_bec", bit_error_count, 6);
        check("burst_ewc", errored_word_count, 4);
        check("burst_wc", word_count, 120);

        // clear_counters on the edge that judges an errored word.
        gen_word(d);
        d[3] = ~d[3];
        step(1'b1, d, 1'b0);
        gen_word(d);
        step(1'b1, d, 1'b1);
        check("clear_bec", bit_error_count, 0);
        check("clear_ewc", errored_word_count, 0);
        check("clear_wc", word_count, 0);
        check("clear_llc", lock_loss_count, 0);
        check("clear_locked", locked, 1);

        // Randomised gaps, sparse random bit flips and occasional clears.
        for (int c = 0; c < 1500; c++) begin
            bit v;
            v = ($urandom_range(0, 1) == 1);
            d = '0;
            if (v) begin
                gen_word(d);
                if ($urandom_range(0, 63) == 0) d[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            end
            step(v, d, ($urandom_range(0, 199) == 0));
        end
        drain(3);

        // Reach lock again, then reset while LOCKED.
        for (int w = 0; w < 80; w++) begin
            gen_word(d);
            step(1'b1, d, 1'b0);
        end
        drain(3);
        check("prereset_locked", locked, 1);
        do_reset("midlock");
        seed_gen();
        for (int w = 0; w < 80; w++) begin
            gen_word(d);
            step(1'b1, d, 1'b0);
        end
        drain(3);
        check("relock_wc", word_count, 80 - 66);

        // Clean stream with roughly 50% valid duty.
        do_reset("gaps");
        seed_gen();
        nvalid = 0;
        while (nvalid < 150) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_word(d);
                step(1'b1, d, 1'b0);
                nvalid++;
            end else begin
                step(1'b0, $urandom(), 1'b0);
            end
        end
        drain(3);
        check("gaps_locked", locked, 1);
        check("gaps_wc", word_count, nvalid - 66);
        check("gaps_bec", bit_error_count, 0);

        // Dead link: all-zero words must never lock.
        do_reset("zero");
        for (int w = 0; w < 120; w++) step(1'b1, '0, 1'b0);
        drain(3);
        check("zero_locked", locked, 0);
        check("zero_bec", bit_error_count, 0);
        check("zero_ewc", errored_word_count, 0);
        check("zero_wc", word_count, 0);

        if (ew_q.size() != 0 || st_q.size() != 0) check("queues_drained", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
